// File: rtl/unidad_pc_fetch.sv
// unidad_pc_fetch: program counter and instruction-fetch sequencer.
// Computes the next fetch address from sequential increment, branch or jump redirects,
// runs the imem_req/imem_ack handshake and reports each delivered instruction's PC.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   stall                      hold: no new fetch is launched after the current ack
//   imem_req, imem_addr        fetch request and byte address (stable until ack)
//   imem_ack                   memory accepted the request and returned data
//   branch_valid/base/offset   taken-branch redirect (target = base + offset)
//   jump_valid/jump_index      J-format redirect, wins over a simultaneous branch
//   pc_out, pc_plus4           PC (and PC+4) of the instruction on the ack cycle
//   instr_valid                combinational from imem_ack; low for wrong-path data
//
// Build option: define BRANCH_DELAY_SLOT_EN for MIPS delay-slot semantics (one extra
// sequential fetch is delivered before the redirect target, nothing is squashed).
module unidad_pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        branch_valid,
    input  logic [31:0] branch_base,
    input  logic [31:0] branch_offset,
    input  logic        jump_valid,
    input  logic [25:0] jump_index,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [1:0]  state, state_next;
    logic [31:0] pc_reg, pc_next;
    logic        req_reg;
    logic        pend, pend_next;
    logic [31:0] pend_tgt, tgt_next;
    logic        redir;
    logic [31:0] target;
    logic [31:0] pc_seq;
`ifdef BRANCH_DELAY_SLOT_EN
    // set while the instruction currently outstanding still precedes the delay slot
    logic        slot_left, slot_next;
`endif

    // redirect target: jump has priority over branch
    always_comb begin
        redir  = jump_valid | branch_valid;
        pc_seq = pc_reg + STEP;
        if (jump_valid) begin
            target = {branch_base[31:28], jump_index, 2'b00};
        end else begin
            target = branch_base + branch_offset;
        end
    end

    // next-state, next-PC and delivery decision
    always_comb begin
        state_next  = state;
        pc_next     = pc_reg;
        pend_next   = pend;
        tgt_next    = pend_tgt;
        instr_valid = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        slot_next   = slot_left;
`endif
        case (state)
            S_IDLE: begin
                state_next = S_REQ;
                if (redir) pc_next = target;
            end
            S_REQ: begin
                if (!imem_ack) begin
                    // address must not move mid-handshake: park the redirect
                    if (redir) begin
                        pend_next = 1'b1;
                        tgt_next  = target;
`ifdef BRANCH_DELAY_SLOT_EN
                        slot_next = pend ? slot_left : 1'b1;
`endif
                    end
                end else begin
                    state_next = stall ? S_HOLD : S_REQ;
`ifdef BRANCH_DELAY_SLOT_EN
                    instr_valid = 1'b1;
                    if (redir) begin
                        pc_next   = pc_seq;
                        pend_next = 1'b1;
                        tgt_next  = target;
                        slot_next = 1'b0;
                    end else if (pend && slot_left) begin
                        pc_next   = pc_seq;
                        slot_next = 1'b0;
                    end else if (pend) begin
                        pc_next   = pend_tgt;
                        pend_next = 1'b0;
                    end else begin
                        pc_next   = pc_seq;
                    end
`else
                    instr_valid = !(pend || redir);
                    pend_next   = 1'b0;
                    if (redir) begin
                        pc_next = target;
                    end else if (pend) begin
                        pc_next = pend_tgt;
                    end else begin
                        pc_next = pc_seq;
                    end
`endif
                end
            end
            S_HOLD: begin
                // nothing outstanding, so a redirect takes effect immediately
                if (redir) begin
                    pc_next   = target;
                    pend_next = 1'b0;
                end
                if (!stall) state_next = S_REQ;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // state and PC registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc_reg   <= RESET_PC;
            req_reg  <= 1'b0;
            pend     <= 1'b0;
            pend_tgt <= RESET_PC;
`ifdef BRANCH_DELAY_SLOT_EN
            slot_left <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            pc_reg   <= pc_next;
            req_reg  <= (state_next == S_REQ);
            pend     <= pend_next;
            pend_tgt <= tgt_next;
`ifdef BRANCH_DELAY_SLOT_EN
            slot_left <= slot_next;
`endif
        end
    end

    assign imem_req  = req_reg;
    assign imem_addr = pc_reg;
    assign pc_out    = pc_reg;
    assign pc_plus4  = pc_reg + STEP;

endmodule

// File: tb/tb_unidad_pc_fetch.sv
// Scoreboard bench for unidad_pc_fetch: each driven fetch pushes its expected
// {instr_valid, pc}; the negedge monitor pops and compares on every ack cycle.
module tb_unidad_pc_fetch;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        branch_valid;
    logic [31:0] branch_base;
    logic [31:0] branch_offset;
    logic        jump_valid;
    logic [25:0] jump_index;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    unidad_pc_fetch dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .branch_valid(branch_valid), .branch_base(branch_base),
        .branch_offset(branch_offset), .jump_valid(jump_valid),
        .jump_index(jump_index), .pc_out(pc_out), .pc_plus4(pc_plus4),
        .instr_valid(instr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int i;
        for (i = 0; i < 20 && !imem_req; i++) tick();
        if (!imem_req) check_eq("req_timeout", 32'd0, 32'd1);
    endtask

    // one accepted fetch; redirect inputs set by the caller apply to the ack cycle
    task automatic fetch(input logic [31:0] a, input logic v);
        wait_req();
        check_eq("req_addr", imem_addr, a);
        exp_q.push_back({v, a});
        imem_ack = 1'b1;
        tick();
        imem_ack     = 1'b0;
        branch_valid = 1'b0;
        jump_valid   = 1'b0;
    endtask

    task automatic branch_to(input logic [31:0] base, input logic [31:0] off);
        branch_valid  = 1'b1;
        branch_base   = base;
        branch_offset = off;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (imem_req && imem_ack) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ack", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("instr_valid", {31'd0, instr_valid}, {31'd0, mon_e[32]});
                check_eq("pc_out", pc_out, mon_e[31:0]);
                check_eq("pc_plus4", pc_plus4, 32'(mon_e[31:0] + 32'd4));
            end
        end else begin
            check_eq("iv_quiet", {31'd0, instr_valid}, 32'd0);
        end
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        branch_valid = 1'b0; branch_base = '0; branch_offset = '0;
        jump_valid = 1'b0; jump_index = '0;
        tick(); tick();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_addr", imem_addr, 32'h0);
        check_eq("rst_pc_out", pc_out, 32'h0);
        check_eq("rst_pc_plus4", pc_plus4, 32'h4);
        rst_n = 1'b1;

        // sequential fetch, ack every request
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);
        fetch(32'h8, 1'b1);
        fetch(32'hC, 1'b1);

        // ack held low 3 cycles: request and address stable
        for (int i = 0; i < 3; i++) begin
            check_eq("wait_req", {31'd0, imem_req}, 32'd1);
            check_eq("wait_addr", imem_addr, 32'h10);
            tick();
        end
        fetch(32'h10, 1'b1);

        // branch during ack-low at 0x14: target 0x20 - 16 = 0x10
        branch_to(32'h20, 32'hFFFF_FFF0);
        tick();
        branch_valid = 1'b0;
        check_eq("pend_addr", imem_addr, 32'h14);
`ifdef BRANCH_DELAY_SLOT_EN
        fetch(32'h14, 1'b1);
        fetch(32'h18, 1'b1);
`else
        fetch(32'h14, 1'b0);
`endif
        fetch(32'h10, 1'b1);

        // jump and branch together during ack-low at 0x14: jump wins
        branch_to(32'h4000_0000, 32'h0000_0100);
        jump_valid = 1'b1;
        jump_index = 26'h000_0040;
        tick();
        branch_valid = 1'b0;
        jump_valid   = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        fetch(32'h14, 1'b1);
        fetch(32'h18, 1'b1);
`else
        fetch(32'h14, 1'b0);
`endif
        fetch(32'h4000_0100, 1'b1);

        // jump on the ack cycle of 0x4000_0104 to 0x8
        branch_base = 32'h0;
        jump_index  = 26'h000_0002;
        jump_valid  = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
        fetch(32'h4000_0104, 1'b1);
        fetch(32'h4000_0108, 1'b1);
`else
        fetch(32'h4000_0104, 1'b0);
`endif

        // stall after the ack at 0x8, branch to 0x100 during the hold
        stall = 1'b1;
        fetch(32'h8, 1'b1);
        check_eq("hold_req1", {31'd0, imem_req}, 32'd0);
        branch_to(32'h100, 32'h0);
        tick();
        branch_valid = 1'b0;
        check_eq("hold_req2", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        check_eq("resume_req", {31'd0, imem_req}, 32'd1);
        fetch(32'h100, 1'b1);

        // jump to 0xFFFF_FFFC during ack-low, then wrap to 0
        branch_base = 32'hF000_0000;
        jump_index  = 26'h3FF_FFFF;
        jump_valid  = 1'b1;
        tick();
        jump_valid = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        fetch(32'h104, 1'b1);
        fetch(32'h108, 1'b1);
`else
        fetch(32'h104, 1'b0);
`endif
        fetch(32'hFFFF_FFFC, 1'b1);
        fetch(32'h0, 1'b1);

        // two redirects while pending: latest wins
        branch_to(32'h200, 32'h0);
        tick();
        branch_to(32'h300, 32'h0);
        tick();
        branch_valid = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
        fetch(32'h4, 1'b1);
        fetch(32'h8, 1'b1);
`else
        fetch(32'h4, 1'b0);
`endif
        fetch(32'h300, 1'b1);

        // reset with a request outstanding and a redirect pending
        branch_to(32'h500, 32'h0);
        tick();
        branch_valid = 1'b0;
        check_eq("pre_rst_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("mid_rst_addr", imem_addr, 32'h0);
        rst_n = 1'b1;
        fetch(32'h0, 1'b1);
        fetch(32'h4, 1'b1);

        tick();
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
